// File: rtl/board_state_writer_if.sv
`default_nettype none
// ============================================================================
// Module      : board_state_writer_if
// Description : Move request / result handshake between game logic and the
//               board state writer.
// Revision    : 1.0 - initial release
// ============================================================================
interface board_state_writer_if #(
    parameter int IDX_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [IDX_W-1:0] req_row;
    logic [IDX_W-1:0] req_col;
    logic [1:0]       req_player;
    logic             resp_valid;
    logic             resp_ready;
    logic [1:0]       resp_code;

    modport master (
        output req_valid, req_row, req_col, req_player, resp_ready,
        input  req_ready, resp_valid, resp_code
    );

    modport slave (
        input  req_valid, req_row, req_col, req_player, resp_ready,
        output req_ready, resp_valid, resp_code
    );
endinterface
`default_nettype wire

// File: rtl/board_state_writer.sv
`default_nettype none
// ============================================================================
// Module      : board_state_writer
// Description : Owns the Gomoku board cells; validates and writes moves,
//               sweeps a full-board clear and serves a combinational read port.
// Revision    : 1.0 - initial release
// ============================================================================
module board_state_writer #(
    parameter int BOARD_N = 15,
    parameter int IDX_W   = 4,
    parameter int CNT_W   = 8
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    board_state_writer_if.slave   bus,
    input  wire logic             clear_start,
    output logic                  busy,
    output logic                  clear_done,
    input  wire logic [IDX_W-1:0] rd_row,
    input  wire logic [IDX_W-1:0] rd_col,
    output logic [1:0]            rd_cell,
    output logic [CNT_W-1:0]      stone_count,
    output logic                  last_valid,
    output logic [IDX_W-1:0]      last_row,
    output logic [IDX_W-1:0]      last_col
);
    localparam int CELLS  = BOARD_N * BOARD_N;
    localparam int LIN_W  = $clog2(CELLS + 1);

    localparam logic [1:0] c_code_placed   = 2'b00;
    localparam logic [1:0] c_code_occupied = 2'b01;
    localparam logic [1:0] c_code_range    = 2'b10;
    localparam logic [1:0] c_code_player   = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RESP  = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t             r_state;
    logic [1:0]         r_cells [CELLS];
    logic [LIN_W-1:0]   r_clr_idx;
    logic               r_resp_valid;
    logic [1:0]         r_resp_code;
    logic               r_busy;
    logic               r_clear_done;
    logic [CNT_W-1:0]   r_stone_count;
    logic               r_last_valid;
    logic [IDX_W-1:0]   r_last_row;
    logic [IDX_W-1:0]   r_last_col;

    logic               w_req_ready;
    logic               w_req_in_range;
    logic               w_rd_in_range;
    logic [LIN_W-1:0]   w_req_idx;
    logic [LIN_W-1:0]   w_rd_idx;
    logic               w_player_ok;
    logic               w_occupied;
    logic [1:0]         w_code;

    assign w_req_ready    = (r_state == IDLE) && !clear_start;
    assign w_req_in_range = (32'(bus.req_row) < BOARD_N) && (32'(bus.req_col) < BOARD_N);
    assign w_rd_in_range  = (32'(rd_row) < BOARD_N) && (32'(rd_col) < BOARD_N);
    assign w_req_idx      = LIN_W'(bus.req_row) * LIN_W'(BOARD_N) + LIN_W'(bus.req_col);
    assign w_rd_idx       = LIN_W'(rd_row) * LIN_W'(BOARD_N) + LIN_W'(rd_col);
    assign w_player_ok    = (bus.req_player == 2'b01) || (bus.req_player == 2'b10);
    assign w_occupied     = w_req_in_range && (r_cells[w_req_idx] != 2'b00);

    always_comb begin
        w_code = c_code_placed;
        if (!w_player_ok)         w_code = c_code_player;
        else if (!w_req_in_range) w_code = c_code_range;
        else if (w_occupied)      w_code = c_code_occupied;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_clr_idx     <= '0;
            r_resp_valid  <= 1'b0;
            r_resp_code   <= 2'b00;
            r_busy        <= 1'b0;
            r_clear_done  <= 1'b0;
            r_stone_count <= '0;
            r_last_valid  <= 1'b0;
            r_last_row    <= '0;
            r_last_col    <= '0;
            for (int i = 0; i < CELLS; i++) begin
                r_cells[i] <= 2'b00;
            end
        end else begin
            r_clear_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (clear_start) begin
                        r_state   <= CLEAR;
                        r_busy    <= 1'b1;
                        r_clr_idx <= '0;
                    end else if (bus.req_valid) begin
                        r_state      <= RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_code  <= w_code;
                        if (w_code == c_code_placed) begin
                            r_cells[w_req_idx] <= bus.req_player;
                            r_last_valid       <= 1'b1;
                            r_last_row         <= bus.req_row;
                            r_last_col         <= bus.req_col;
                            // Guard only: a full board can never accept another stone.
                            if (r_stone_count != CNT_W'(CELLS)) begin
                                r_stone_count <= r_stone_count + 1'b1;
                            end
                        end
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        r_state      <= IDLE;
                        r_resp_valid <= 1'b0;
                    end
                end
                CLEAR: begin
                    r_cells[r_clr_idx] <= 2'b00;
                    if (r_clr_idx == LIN_W'(CELLS - 1)) begin
                        r_state       <= IDLE;
                        r_busy        <= 1'b0;
                        r_clear_done  <= 1'b1;
                        r_stone_count <= '0;
                        r_last_valid  <= 1'b0;
                    end else begin
                        r_clr_idx <= r_clr_idx + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = w_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_code  = r_resp_code;
    assign busy           = r_busy;
    assign clear_done     = r_clear_done;
    assign rd_cell        = w_rd_in_range ? r_cells[w_rd_idx] : 2'b11;
    assign stone_count    = r_stone_count;
    assign last_valid     = r_last_valid;
    assign last_row       = r_last_row;
    assign last_col       = r_last_col;
endmodule
`default_nettype wire
